// File: rtl/fc_popcount_seq.sv
// fc_popcount_seq: sequencer for the BNN XNOR-popcount fully-connected stage.
// Walks N_OUT neurons, each: clear, stream N_IN bit pairs, settle, flag sum.
// Ports: iCLK/iRST_N clock and async active-low reset; iSTART begins a pass;
//   iIN_VLD input/weight bits valid; iSUM datapath sum (argmax build only);
//   oCLR/oEN datapath clear and accumulate enable; oIN_ADDR/oW_ADDR bit and
//   weight addresses; oNEURON current neuron; oVALID sum final; oBUSY not idle;
//   oDONE pass complete; oCLASS argmax neuron index.
// Optional: define FC_SEQ_ARGMAX_EN to track the argmax of iSUM into oCLASS.
module fc_popcount_seq #(
    parameter int N_IN  = 54,
    parameter int N_OUT = 10,
    parameter int OL    = 7,
    parameter int IN_AW = 6,
    parameter int NO_AW = 4,
    parameter int W_AW  = 10
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic                 iSTART,
    input  logic                 iIN_VLD,
    input  logic signed [OL-1:0] iSUM,
    output logic                 oCLR,
    output logic                 oEN,
    output logic [IN_AW-1:0]     oIN_ADDR,
    output logic [W_AW-1:0]      oW_ADDR,
    output logic [NO_AW-1:0]     oNEURON,
    output logic                 oVALID,
    output logic                 oBUSY,
    output logic                 oDONE,
    output logic [NO_AW-1:0]     oCLASS
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ACC,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [IN_AW-1:0] BIT_LAST = IN_AW'(N_IN - 1);
    localparam logic [NO_AW-1:0] NEU_LAST = NO_AW'(N_OUT - 1);

    state_t           state_q, state_d;
    logic [IN_AW-1:0] bit_q, bit_d;
    logic [W_AW-1:0]  w_q, w_d;
    logic [NO_AW-1:0] neuron_q, neuron_d;
    logic             clr_q, valid_q, busy_q, done_q;
    logic             accept;

    assign accept = (state_q == S_ACC) && iIN_VLD;

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        w_d      = w_q;
        neuron_d = neuron_q;
        unique case (state_q)
            S_IDLE: begin
                if (iSTART) begin
                    state_d  = S_CLR;
                    neuron_d = '0;
                    bit_d    = '0;
                    w_d      = '0;
                end
            end
            S_CLR: begin
                bit_d   = '0;
                state_d = S_ACC;
            end
            S_ACC: begin
                // Addresses only move on accepted bits; a stall holds them.
                if (iIN_VLD) begin
                    w_d = w_q + W_AW'(1);
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        bit_d = bit_q + IN_AW'(1);
                    end
                end
            end
            S_WAIT: state_d = S_EMIT;
            S_EMIT: begin
                if (neuron_q == NEU_LAST) begin
                    state_d = S_DONE;
                end else begin
                    neuron_d = neuron_q + NO_AW'(1);
                    state_d  = S_CLR;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= S_IDLE;
            bit_q    <= '0;
            w_q      <= '0;
            neuron_q <= '0;
            clr_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            w_q      <= w_d;
            neuron_q <= neuron_d;
            // Flags decoded from the next state so they leave a flop.
            clr_q    <= (state_d == S_CLR);
            valid_q  <= (state_d == S_EMIT);
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DONE);
        end
    end

    assign oCLR     = clr_q;
    assign oEN      = accept;
    assign oIN_ADDR = bit_q;
    assign oW_ADDR  = w_q;
    assign oNEURON  = neuron_q;
    assign oVALID   = valid_q;
    assign oBUSY    = busy_q;
    assign oDONE    = done_q;

`ifdef FC_SEQ_ARGMAX_EN
    logic signed [OL-1:0] max_q;
    logic [NO_AW-1:0]     idx_q;
    logic [NO_AW-1:0]     class_q;
    logic                 take;

    // Neuron 0 seeds the max; later ties keep the lower index.
    assign take = (neuron_q == '0) || (iSUM > max_q);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            max_q   <= '0;
            idx_q   <= '0;
            class_q <= '0;
        end else if (state_q == S_EMIT) begin
            if (take) begin
                max_q <= iSUM;
                idx_q <= neuron_q;
            end
            // Last neuron folds straight into oCLASS so it is valid in DONE.
            if (neuron_q == NEU_LAST) begin
                class_q <= take ? neuron_q : idx_q;
            end
        end
    end

    assign oCLASS = class_q;
`else
    logic unused_sum;
    assign unused_sum = ^iSUM;
    assign oCLASS     = '0;
`endif

endmodule

// File: tb/tb_fc_popcount_seq.sv
// tb_fc_popcount_seq: scoreboard bench for fc_popcount_seq.
// Stimulus queues expected neuron/latency; a negedge monitor compares.
module tb_fc_popcount_seq;

    localparam int N_IN  = 54;
    localparam int N_OUT = 10;
    localparam int OL    = 7;
    localparam int IN_AW = 6;
    localparam int NO_AW = 4;
    localparam int W_AW  = 10;
    localparam int PER   = 10;
`ifdef FC_SEQ_ARGMAX_EN
    localparam int EXP_CLASS = 2;
`else
    localparam int EXP_CLASS = 0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 in_vld;
    logic signed [OL-1:0] sum;
    logic                 clr, en, valid, busy, done;
    logic [IN_AW-1:0]     in_addr;
    logic [W_AW-1:0]      w_addr;
    logic [NO_AW-1:0]     neuron, cls;

    int  checks = 0;
    int  errors = 0;
    int  vld_q[$];
    int  lat_q[$];
    time t_start;
    int  exp_w = 0;
    int  exp_b = 0;
    int  sum_tab[10] = '{-4, 10, 36, -54, 36, 2, 0, 12, -1, 8};

    always #(PER/2) clk = ~clk;

    fc_popcount_seq #(
        .N_IN(N_IN), .N_OUT(N_OUT), .OL(OL),
        .IN_AW(IN_AW), .NO_AW(NO_AW), .W_AW(W_AW)
    ) dut (
        .iCLK(clk), .iRST_N(rst_n), .iSTART(start), .iIN_VLD(in_vld),
        .iSUM(sum), .oCLR(clr), .oEN(en), .oIN_ADDR(in_addr),
        .oW_ADDR(w_addr), .oNEURON(neuron), .oVALID(valid),
        .oBUSY(busy), .oDONE(done), .oCLASS(cls)
    );

    always_comb begin
        sum = '0;
        if (int'(neuron) < N_OUT) sum = OL'(sum_tab[int'(neuron)]);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        int e;
        if (rst_n === 1'b1) begin
            if (en) begin
                chk("w_addr", w_addr, exp_w);
                chk("in_addr", in_addr, exp_b);
                exp_w++;
                exp_b = (exp_b == N_IN - 1) ? 0 : exp_b + 1;
            end
            if (valid) begin
                chk("valid_expected", vld_q.size() > 0, 1);
                if (vld_q.size() > 0) begin
                    e = vld_q.pop_front();
                    chk("valid_neuron", neuron, e);
                    chk("valid_en_clr", {en, clr}, 0);
                end
            end
            if (done) begin
                chk("done_expected", lat_q.size() > 0, 1);
                if (lat_q.size() > 0) begin
                    e = lat_q.pop_front();
                    chk("done_latency", (($time - t_start) - PER/2) / PER, e);
                    chk("done_valids_left", vld_q.size(), 0);
                    chk("done_class", cls, EXP_CLASS);
                    chk("done_w_count", exp_w, N_IN * N_OUT);
                end
            end
        end
    end

    task automatic start_pass(input int lat);
        for (int n = 0; n < N_OUT; n++) vld_q.push_back(n);
        lat_q.push_back(lat);
        @(posedge clk);
        t_start = $time;
        #1;
        exp_w = 0;
        exp_b = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("clr_after_start", clr, 1);
    endtask

    // mode 0 plain, 3 stall at n3/b20, 4 restart pulse at n2, 5 reset at n6
    task automatic wait_done(input int mode);
        bit fin = 0;
        bit acted = 0;
        for (int i = 0; i < 700 && !fin; i++) begin
            @(posedge clk);
            #1;
            if (mode == 3 && !acted && en && neuron == 3 && in_addr == 20) begin
                acted = 1;
                in_vld = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    #1;
                    chk("stall_en", en, 0);
                    chk("stall_in_addr", in_addr, 20);
                    chk("stall_w_addr", w_addr, 3 * N_IN + 20);
                    @(posedge clk);
                    #1;
                end
                in_vld = 1'b1;
            end else if (mode == 4 && !acted && en && neuron == 2) begin
                acted = 1;
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end else if (mode == 5 && en && neuron == 6) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mid_outs", {clr, en, valid, busy, done}, 0);
                chk("rst_mid_neuron", neuron, 0);
                chk("rst_mid_addr", {in_addr, w_addr}, 0);
                chk("rst_mid_class", cls, 0);
                vld_q.delete();
                lat_q.delete();
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                fin = 1;
            end
            if (done) fin = 1;
        end
        if (mode != 5) chk("done_seen", done, 1);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        in_vld = 1'b1;
        #23;
        chk("rst_flags", {clr, en, valid, busy, done}, 0);
        chk("rst_neuron", neuron, 0);
        chk("rst_addr", {in_addr, w_addr}, 0);
        chk("rst_class", cls, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        start_pass(N_OUT * (N_IN + 3) + 1);
        wait_done(0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_neuron_hold", neuron, N_OUT - 1);

        start_pass(N_OUT * (N_IN + 3) + 1 + 5);
        wait_done(3);
        repeat (3) @(posedge clk);

        start_pass(N_OUT * (N_IN + 3) + 1);
        wait_done(4);
        repeat (5) @(posedge clk);

        start_pass(N_OUT * (N_IN + 3) + 1);
        wait_done(5);
        repeat (30) @(posedge clk);
        #1;
        chk("post_rst_idle", busy, 0);
        start_pass(N_OUT * (N_IN + 3) + 1);
        wait_done(0);

        repeat (5) @(posedge clk);
        #1;
        chk("queues_empty", vld_q.size() + lat_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
